// File: rtl/obd_frame_tx.sv
// obd_frame_tx: snapshots vehicle state and sends it as a UART 8N1 frame.
// Define OBD_TX_CHECKSUM_EN to append an XOR checksum byte (12-byte frame instead of 11).
module obd_frame_tx #(
   parameter int BAUD_DIV = 5208
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        send_req,
   input  logic        engine_on,
   input  logic [7:0]  speed,
   input  logic [13:0] rpm,
   input  logic [7:0]  fuel,
   input  logic [7:0]  temp,
   input  logic [31:0] odometer_raw,
   input  logic [2:0]  gear_num,
   input  logic        ess_trigger,
   output logic        tx,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  drop_cnt
);
`ifdef OBD_TX_CHECKSUM_EN
   localparam logic [3:0] LAST = 4'd11;
`else
   localparam logic [3:0] LAST = 4'd10;
`endif
   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state;

   logic [15:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic [3:0]  byte_idx;
   logic        pending, ess_latch;
   logic [7:0]  s_speed, s_fuel, s_temp, s_stat;
   logic [13:0] s_rpm;
   logic [31:0] s_odo;
   logic [7:0]  cur_byte, csum;
   logic        bit_end, fin, launch;

   assign bit_end = baud_cnt == BAUD_LAST;
   assign fin     = state == STOP && bit_end && byte_idx == LAST;
   // a pending request relaunches on the final stop-bit edge, so frames run back to back
   assign launch  = (state == IDLE && (send_req || pending)) || (fin && pending);

   // XOR of the eleven payload bytes, taken from the snapshot
   always_comb csum = 8'hA5 ^ s_speed ^ {2'b00, s_rpm[13:8]} ^ s_rpm[7:0] ^ s_fuel ^ s_temp
                      ^ s_odo[31:24] ^ s_odo[23:16] ^ s_odo[15:8] ^ s_odo[7:0] ^ s_stat;

   // select the byte currently on the wire
   always_comb begin
      case (byte_idx)
         4'd0:    cur_byte = 8'hA5;
         4'd1:    cur_byte = s_speed;
         4'd2:    cur_byte = {2'b00, s_rpm[13:8]};
         4'd3:    cur_byte = s_rpm[7:0];
         4'd4:    cur_byte = s_fuel;
         4'd5:    cur_byte = s_temp;
         4'd6:    cur_byte = s_odo[31:24];
         4'd7:    cur_byte = s_odo[23:16];
         4'd8:    cur_byte = s_odo[15:8];
         4'd9:    cur_byte = s_odo[7:0];
         4'd10:   cur_byte = s_stat;
         default: cur_byte = csum;
      endcase
   end

   // UART framing FSM with registered line, busy and done outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         baud_cnt   <= 16'd0;
         bit_idx    <= 3'd0;
         byte_idx   <= 4'd0;
      end else begin
         frame_done <= 1'b0;
         baud_cnt   <= (state == IDLE || bit_end) ? 16'd0 : baud_cnt + 16'd1;
         case (state)
            IDLE: if (launch) begin
               state    <= START;
               tx       <= 1'b0;
               busy     <= 1'b1;
               byte_idx <= 4'd0;
               bit_idx  <= 3'd0;
            end
            START: begin
               busy <= 1'b1;
               if (bit_end) begin
                  state <= DATA;
                  tx    <= cur_byte[0];
               end
            end
            DATA: if (bit_end) begin
               if (bit_idx == 3'd7) begin
                  state <= STOP;
                  tx    <= 1'b1;
               end else
                  tx <= cur_byte[bit_idx + 3'd1];
               bit_idx <= bit_idx + 3'd1;
            end
            STOP: if (bit_end) begin
               if (byte_idx != LAST) begin
                  state    <= START;
                  tx       <= 1'b0;
                  byte_idx <= byte_idx + 4'd1;
               end else begin
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
                  byte_idx   <= 4'd0;
                  state      <= pending ? START : IDLE;
                  tx         <= !pending;
               end
            end
         endcase
      end
   end

   // snapshot capture, ESS latch, request queueing and drop counting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= 1'b0;
         ess_latch <= 1'b0;
         drop_cnt  <= 8'd0;
         s_speed   <= 8'd0;
         s_rpm     <= 14'd0;
         s_fuel    <= 8'd0;
         s_temp    <= 8'd0;
         s_odo     <= 32'd0;
         s_stat    <= 8'd0;
      end else begin
         ess_latch <= launch ? ess_trigger : ess_latch | ess_trigger;
         if (launch) begin
            pending <= pending & send_req;
            s_speed <= speed;
            s_rpm   <= rpm;
            s_fuel  <= fuel;
            s_temp  <= temp;
            s_odo   <= odometer_raw;
            s_stat  <= {engine_on, ess_latch, 1'b0, gear_num, 2'b00};
         end else if (send_req) begin
            if (!pending)
               pending <= 1'b1;
            else if (drop_cnt != 8'hFF)
               drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_obd_frame_tx.sv
// tb_obd_frame_tx: directed bench for obd_frame_tx with BAUD_DIV=4 and a bit-sampling UART receiver.
module tb_obd_frame_tx;
`ifdef OBD_TX_CHECKSUM_EN
   localparam int NB = 12;
`else
   localparam int NB = 11;
`endif
   localparam int RX_LIMIT = 1200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        send_req = 1'b0;
   logic        engine_on = 1'b0;
   logic [7:0]  speed = 8'd0;
   logic [13:0] rpm = 14'd0;
   logic [7:0]  fuel = 8'd0;
   logic [7:0]  temp = 8'd0;
   logic [31:0] odometer_raw = 32'd0;
   logic [2:0]  gear_num = 3'd0;
   logic        ess_trigger = 1'b0;
   logic        tx, busy, frame_done;
   logic [7:0]  drop_cnt;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_count = 0;
   int last_done = 0;
   logic [7:0] rx[12], rx1[12], ex[12], exa[12];

   obd_frame_tx #(.BAUD_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .send_req(send_req), .engine_on(engine_on),
      .speed(speed), .rpm(rpm), .fuel(fuel), .temp(temp),
      .odometer_raw(odometer_raw), .gear_num(gear_num), .ess_trigger(ess_trigger),
      .tx(tx), .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      if (frame_done === 1'b1) begin
         done_count <= done_count + 1;
         last_done  <= cyc;
      end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_req();
      send_req = 1'b1;
      tick(1);
      send_req = 1'b0;
   endtask

   task automatic recv_byte(output logic [7:0] b, output int idle);
      idle = 0;
      b = 8'h00;
      while (tx !== 1'b0 && idle < RX_LIMIT) begin
         tick(1);
         idle++;
      end
      if (idle >= RX_LIMIT) begin
         check("rx_timeout", idle, 0);
         return;
      end
      tick(2);
      for (int i = 0; i < 8; i++) begin
         tick(4);
         b[i] = tx;
      end
      tick(4);
   endtask

   task automatic recv_frame(output int gap);
      logic [7:0] b;
      int g;
      gap = 0;
      for (int i = 0; i < NB; i++) begin
         recv_byte(b, g);
         rx[i] = b;
         if (i == 0) gap = g;
      end
   endtask

   task automatic cmp_frame(input string tag);
      for (int i = 0; i < NB; i++)
         check($sformatf("%s_b%0d", tag, i), rx[i], ex[i]);
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_count < target && n < 3000) begin
         tick(1);
         n++;
      end
      if (n >= 3000) check("done_timeout", done_count, target);
   endtask

   function automatic void mk_exp(input logic ess);
      ex[0]  = 8'hA5;
      ex[1]  = speed;
      ex[2]  = {2'b00, rpm[13:8]};
      ex[3]  = rpm[7:0];
      ex[4]  = fuel;
      ex[5]  = temp;
      ex[6]  = odometer_raw[31:24];
      ex[7]  = odometer_raw[23:16];
      ex[8]  = odometer_raw[15:8];
      ex[9]  = odometer_raw[7:0];
      ex[10] = {engine_on, ess, 1'b0, gear_num, 2'b00};
      ex[11] = 8'h00;
      for (int i = 0; i < 11; i++) ex[11] ^= ex[i];
   endfunction

   initial begin
      int gap, g2, d0, errs, req_cyc;
      // reset and idle
      tick(3);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_drop", drop_cnt, 0);
      rst_n = 1'b1;
      errs = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (tx !== 1'b1 || busy !== 1'b0) errs++;
      end
      check("idle_stable", errs, 0);
      check("idle_drop", drop_cnt, 0);

      // single frame with hand-computed bytes
      speed = 8'd100; rpm = 14'h0A3C; fuel = 8'd50; temp = 8'd90;
      odometer_raw = 32'h00012345; gear_num = 3'd4; engine_on = 1'b1;
      ex = '{8'hA5, 8'h64, 8'h0A, 8'h3C, 8'h32, 8'h5A, 8'h00, 8'h01, 8'h23, 8'h45, 8'h90, 8'h68};
      d0 = done_count;
      req_cyc = cyc;
      pulse_req();
      check("start_bit", tx, 0);
      check("busy_rise", busy, 1);
      recv_frame(gap);
      check("first_gap", gap, 0);
      cmp_frame("single");
      wait_done(d0 + 1);
      check("done_latency", last_done - req_cyc, NB * 40 + 1);
      tick(2);
      check("busy_fall", busy, 0);

      // ESS pulse captured into exactly one frame
      speed = 8'd7; rpm = 14'h3FFF; fuel = 8'hFF; temp = 8'd0;
      odometer_raw = 32'hDEADBEEF; gear_num = 3'd6; engine_on = 1'b0;
      ess_trigger = 1'b1;
      tick(1);
      ess_trigger = 1'b0;
      tick(5);
      pulse_req();
      recv_frame(gap);
      mk_exp(1'b1);
      cmp_frame("ess1");
      check("ess1_bit6", rx[10][6], 1);
      tick(20);
      pulse_req();
      recv_frame(gap);
      mk_exp(1'b0);
      cmp_frame("ess2");
      check("ess2_bit6", rx[10][6], 0);
      tick(20);

      // three requests: one launches, one pends, one drops; pending frame uses launch-time values
      speed = 8'd1; rpm = 14'h0100; fuel = 8'd2; temp = 8'd3;
      odometer_raw = 32'h01020304; gear_num = 3'd1; engine_on = 1'b1;
      mk_exp(1'b0);
      exa = ex;
      d0 = done_count;
      pulse_req();
      fork
         begin
            recv_frame(gap);
            rx1 = rx;
            recv_frame(g2);
         end
         begin
            tick(60);
            pulse_req();
            tick(60);
            pulse_req();
            tick(20);
            speed = 8'd200; rpm = 14'h2001; fuel = 8'd9; temp = 8'd250;
            odometer_raw = 32'hFFFFFFFF; gear_num = 3'd2; engine_on = 1'b0;
         end
      join
      mk_exp(1'b0);
      cmp_frame("pend2");
      check("b2b_gap", g2, 2);
      rx = rx1;
      ex = exa;
      cmp_frame("pend1");
      check("pend_drop", drop_cnt, 1);
      wait_done(d0 + 2);
      tick(100);
      check("pend_frames", done_count - d0, 2);
      check("pend_idle_tx", tx, 1);
      check("pend_idle_busy", busy, 0);

      // saturation of the drop counter
      d0 = done_count;
      send_req = 1'b1;
      tick(300);
      send_req = 1'b0;
      wait_done(d0 + 2);
      check("drop_sat", drop_cnt, 255);
      d0 = done_count;
      pulse_req();
      tick(10);
      for (int i = 0; i < 5; i++) begin
         pulse_req();
         tick(3);
      end
      check("drop_nowrap", drop_cnt, 255);
      wait_done(d0 + 2);
      tick(10);

      // reset in the start bit of byte 5, then a clean frame
      speed = 8'd55; rpm = 14'h1234; fuel = 8'd77; temp = 8'd33;
      odometer_raw = 32'h0BADF00D; gear_num = 3'd3; engine_on = 1'b1;
      pulse_req();
      tick(201);
      check("b5_start_low", tx, 0);
      rst_n = 1'b0;
      #1;
      check("arst_tx", tx, 1);
      check("arst_busy", busy, 0);
      check("arst_drop", drop_cnt, 0);
      tick(3);
      rst_n = 1'b1;
      tick(5);
      check("post_rst_tx", tx, 1);
      d0 = done_count;
      pulse_req();
      recv_frame(gap);
      mk_exp(1'b0);
      cmp_frame("post_rst");
      wait_done(d0 + 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
